fsm_cmd_issuer: RTL

- Initiator for the control FSM's `op`/`select` command interface; drives the two inputs that the FSM's next-state logic consumes.
- Accepts one command per valid/ready handshake and drives the matching `op`/`select` levels for exactly one clock.
- Monitors the FSM's 2-bit `current_state` until it reaches the expected state, then reports done, or reports error on timeout.
- Sits between the top-level control/user logic and the control FSM.

---
 rtl/fsm_pkg.sv | 29 ++
 rtl/issuer_timeout_cnt.sv | 30 +++
 rtl/fsm_cmd_issuer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared types for the control FSM and its command issuer.
package fsm_pkg;

    // Control FSM state register encoding.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } fsm_state_t;

    // Command issuer internal states.
    typedef enum logic [1:0] {
        ISS_IDLE  = 2'd0,
        ISS_DRIVE = 2'd1,
        ISS_WAIT  = 2'd2,
        ISS_RESP  = 2'd3
    } issuer_state_t;

    // Command payload as presented by the requester.
    typedef struct packed {
        logic       op;
        logic       sel;
        fsm_state_t exp_state;
    } issuer_cmd_t;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/issuer_timeout_cnt.sv
// WAIT-cycle counter: clears on request, counts while enabled, saturates at TIMEOUT_CYCLES-1.
module issuer_timeout_cnt #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter register; holds at the terminal value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != TC_VAL)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/fsm_cmd_issuer.sv
// Issues one op/select pulse per accepted command and watches the control FSM
// state until it reaches the expected value (done) or the WAIT budget runs out (error).
module fsm_cmd_issuer
    import fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic       cmd_select,
    input  logic [1:0] cmd_expect,
    input  logic [1:0] current_state,
    output logic       op,
    output logic       select,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] last_state
);

    issuer_state_t state_q;
    fsm_state_t    exp_q;
    logic          op_q;
    logic          sel_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          ready_q;
    logic [1:0]    last_q;

    logic match_c;
    logic cnt_clear_c;
    logic cnt_en_c;
    logic tc_c;

    // current_state only matters while waiting; the counter restarts in DRIVE.
    assign match_c     = (current_state == exp_q);
    assign cnt_clear_c = (state_q == ISS_DRIVE);
    assign cnt_en_c    = (state_q == ISS_WAIT) && !match_c;

    issuer_timeout_cnt #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear_c),
        .en_i    (cnt_en_c),
        .tc_o    (tc_c)
    );

    // Issuer FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ISS_IDLE;
            exp_q   <= S0;
            op_q    <= 1'b0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ready_q <= 1'b1;
            last_q  <= 2'b00;
        end else begin
            op_q    <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ISS_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        exp_q   <= fsm_state_t'(cmd_expect);
                        op_q    <= cmd_op;
                        sel_q   <= cmd_select;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= ISS_DRIVE;
                    end
                end
                ISS_DRIVE: begin
                    state_q <= ISS_WAIT;
                end
                ISS_WAIT: begin
                    // A match on the terminal cycle takes priority over timeout.
                    if (match_c) begin
                        last_q  <= current_state;
                        done_q  <= 1'b1;
                        state_q <= ISS_RESP;
                    end else if (tc_c) begin
                        last_q  <= current_state;
                        error_q <= 1'b1;
                        state_q <= ISS_RESP;
                    end
                end
                ISS_RESP: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ISS_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ISS_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = ready_q;
    assign op         = op_q;
    assign select     = sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign last_state = last_q;

endmodule
